// File: rtl/mastermind_game_core_if.sv
`default_nettype none
// ============================================================================
// mastermind_game_core_if : peg-entry and scoring-result bundle for the game core
// Rev 1.0
// ============================================================================
interface mastermind_game_core_if #(
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8
);
  localparam int CNT_W = $clog2(PEGS + 1);
  localparam int GC_W  = $clog2(MAX_GUESSES + 1);

  logic                      load;
  logic [COLOR_W-1:0]        data_in;
  logic                      new_game;
  logic [PEGS*COLOR_W-1:0]   code;
  logic [PEGS*COLOR_W-1:0]   guess;
  logic [CNT_W-1:0]          red;
  logic [CNT_W-1:0]          white;
  logic [GC_W-1:0]           guess_count;
  logic                      result_valid;
  logic                      win;
  logic                      lose;
  logic                      busy;

  modport master (
    output load, data_in, new_game,
    input  code, guess, red, white, guess_count, result_valid, win, lose, busy
  );

  modport slave (
    input  load, data_in, new_game,
    output code, guess, red, white, guess_count, result_valid, win, lose, busy
  );
endinterface
`default_nettype wire

// File: rtl/mastermind_game_core.sv
`default_nettype none
// ============================================================================
// mastermind_game_core : parametrised Mastermind engine, peg entry + red/white scoring
// Rev 1.0
// ============================================================================
module mastermind_game_core #(
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mastermind_game_core_if.slave bus
);
  localparam int CNT_W = $clog2(PEGS + 1);
  localparam int GC_W  = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W = $clog2(PEGS);

  localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(PEGS - 1);
  localparam logic [CNT_W-1:0] C_PEGS       = CNT_W'(PEGS);
  localparam logic [GC_W-1:0]  C_MAX_GUESS  = GC_W'(MAX_GUESSES);
  localparam logic [GC_W-1:0]  C_LAST_GUESS = GC_W'(MAX_GUESSES - 1);

  typedef enum logic [2:0] {
    LOAD_CODE   = 3'd0,
    LOAD_GUESS  = 3'd1,
    SCORE_RED   = 3'd2,
    SCORE_WHITE = 3'd3,
    DONE        = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [COLOR_W-1:0] r_code  [PEGS];
  logic [COLOR_W-1:0] r_guess [PEGS];
  logic [PEGS-1:0]    r_code_used;
  logic [PEGS-1:0]    r_guess_used;
  logic [CNT_W-1:0]   r_red_acc;
  logic [CNT_W-1:0]   r_white_acc;
  logic [CNT_W-1:0]   r_red;
  logic [CNT_W-1:0]   r_white;
  logic [GC_W-1:0]    r_gc;
  logic               r_win;
  logic               r_lose;
  logic               r_valid;
  logic               r_busy;
  logic               r_load_prev;

  logic               w_load_edge;
  logic               w_red_hit;
  logic               w_white_hit;
  logic [IDX_W-1:0]   w_white_idx;
  logic [CNT_W-1:0]   w_white_next;
  logic               w_win;
  logic               w_lose;

  assign w_load_edge  = bus.load & ~r_load_prev;
  assign w_red_hit    = (r_code[r_idx] == r_guess[r_idx]);
  assign w_white_next = r_white_acc + CNT_W'(w_white_hit);
  assign w_win        = (r_red_acc == C_PEGS);
  assign w_lose       = !w_win && (r_gc == C_LAST_GUESS);

  // Descending scan so the lowest unused matching code peg wins.
  always_comb begin
    w_white_hit = 1'b0;
    w_white_idx = '0;
    for (int c = PEGS - 1; c >= 0; c--) begin
      if (!r_guess_used[r_idx] && !r_code_used[c] && (r_code[c] == r_guess[r_idx])) begin
        w_white_hit = 1'b1;
        w_white_idx = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.new_game) begin
      r_state      <= LOAD_CODE;
      r_idx        <= '0;
      r_code       <= '{default: '0};
      r_guess      <= '{default: '0};
      r_code_used  <= '0;
      r_guess_used <= '0;
      r_red_acc    <= '0;
      r_white_acc  <= '0;
      r_red        <= '0;
      r_white      <= '0;
      r_gc         <= '0;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_load_prev  <= 1'b0;
    end else begin
      // Edge history tracks the key in every state so a held key never retriggers.
      r_load_prev <= bus.load;
      r_valid     <= 1'b0;
      case (r_state)
        LOAD_CODE: begin
          if (w_load_edge) begin
            r_code[r_idx] <= bus.data_in;
            if (r_idx == C_LAST_IDX) begin
              r_idx   <= '0;
              r_state <= LOAD_GUESS;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        LOAD_GUESS: begin
          if (w_load_edge) begin
            r_guess[r_idx] <= bus.data_in;
            if (r_idx == C_LAST_IDX) begin
              r_idx        <= '0;
              r_state      <= SCORE_RED;
              r_busy       <= 1'b1;
              r_red_acc    <= '0;
              r_white_acc  <= '0;
              r_code_used  <= '0;
              r_guess_used <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        SCORE_RED: begin
          if (w_red_hit) begin
            r_red_acc           <= r_red_acc + CNT_W'(1);
            r_code_used[r_idx]  <= 1'b1;
            r_guess_used[r_idx] <= 1'b1;
          end
          if (r_idx == C_LAST_IDX) begin
            r_idx   <= '0;
            r_state <= SCORE_WHITE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        SCORE_WHITE: begin
          if (w_white_hit) begin
            r_white_acc              <= w_white_next;
            r_code_used[w_white_idx] <= 1'b1;
          end
          if (r_idx == C_LAST_IDX) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_red   <= r_red_acc;
            r_white <= w_white_next;
            r_win   <= w_win;
            r_lose  <= w_lose;
            if (r_gc != C_MAX_GUESS) begin
              r_gc <= r_gc + GC_W'(1);
            end
            r_state <= (w_win || w_lose) ? DONE : LOAD_GUESS;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
        end
        default: r_state <= LOAD_CODE;
      endcase
    end
  end

  for (genvar i = 0; i < PEGS; i++) begin : g_pack
    assign bus.code[i*COLOR_W +: COLOR_W]  = r_code[i];
    assign bus.guess[i*COLOR_W +: COLOR_W] = r_guess[i];
  end

  assign bus.red          = r_red;
  assign bus.white        = r_white;
  assign bus.guess_count  = r_gc;
  assign bus.result_valid = r_valid;
  assign bus.win          = r_win;
  assign bus.lose         = r_lose;
  assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mastermind_game_core.sv
`default_nettype none
// ============================================================================
// tb_mastermind_game_core : directed + random games on 4-peg and 6-peg instances
// Rev 1.0
// ============================================================================
module tb_mastermind_game_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       new_game = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] data = '0;

  always #5 clk = ~clk;

  mastermind_game_core_if #(.PEGS(4), .COLOR_W(3), .MAX_GUESSES(8)) if4 ();
  mastermind_game_core_if #(.PEGS(6), .COLOR_W(4), .MAX_GUESSES(8)) if6 ();

  assign if4.load     = load & ~sel;
  assign if4.data_in  = data[2:0];
  assign if4.new_game = new_game;
  assign if6.load     = load & sel;
  assign if6.data_in  = data;
  assign if6.new_game = new_game;

  mastermind_game_core #(.PEGS(4), .COLOR_W(3), .MAX_GUESSES(8)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4));
  mastermind_game_core #(.PEGS(6), .COLOR_W(4), .MAX_GUESSES(8)) u_dut6 (
    .clk(clk), .reset(reset), .bus(if6));

  logic [23:0] o_code, o_guess;
  logic [2:0]  o_red, o_white;
  logic [3:0]  o_gc;
  logic        o_valid, o_win, o_lose, o_busy;
  assign o_code  = sel ? if6.code  : {12'd0, if4.code};
  assign o_guess = sel ? if6.guess : {12'd0, if4.guess};
  assign o_red   = sel ? if6.red   : if4.red;
  assign o_white = sel ? if6.white : if4.white;
  assign o_gc    = sel ? if6.guess_count  : if4.guess_count;
  assign o_valid = sel ? if6.result_valid : if4.result_valid;
  assign o_win   = sel ? if6.win  : if4.win;
  assign o_lose  = sel ? if6.lose : if4.lose;
  assign o_busy  = sel ? if6.busy : if4.busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference game state
  int P  = 4;
  int CW = 3;
  int mc[6];
  int mg[6];
  int e_gc = 0;
  bit e_over = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Red = positional matches; red+white = per-colour overlap of the two multisets.
  function automatic void score(output int r, output int w);
    int cc[16];
    int gg[16];
    int tot;
    r = 0;
    tot = 0;
    for (int k = 0; k < 16; k++) begin cc[k] = 0; gg[k] = 0; end
    for (int i = 0; i < P; i++) begin
      if (mc[i] == mg[i]) r++;
      cc[mc[i]]++;
      gg[mg[i]]++;
    end
    for (int k = 0; k < 16; k++) tot += (cc[k] < gg[k]) ? cc[k] : gg[k];
    w = tot - r;
  endfunction

  function automatic logic [23:0] pack_code();
    logic [23:0] v = '0;
    for (int i = 0; i < P; i++) v = v | (24'(mc[i]) << (i * CW));
    return v;
  endfunction

  function automatic logic [23:0] pack_guess();
    logic [23:0] v = '0;
    for (int i = 0; i < P; i++) v = v | (24'(mg[i]) << (i * CW));
    return v;
  endfunction

  task automatic select(input bit s);
    sel = s;
    P   = s ? 6 : 4;
    CW  = s ? 4 : 3;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_code"},  32'(o_code), 0);
    chk({tag, "_guess"}, 32'(o_guess), 0);
    chk({tag, "_red"},   32'(o_red), 0);
    chk({tag, "_white"}, 32'(o_white), 0);
    chk({tag, "_gc"},    32'(o_gc), 0);
    chk({tag, "_win"},   32'(o_win), 0);
    chk({tag, "_lose"},  32'(o_lose), 0);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    e_gc   = 0;
    e_over = 1'b0;
  endtask

  task automatic pulse(input int v, input bit hold_low);
    data = 4'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (hold_low) @(negedge clk);
  endtask

  task automatic load_code(input int first);
    for (int i = first; i < P; i++) pulse(mc[i], 1'b1);
    chk("code_loaded", 32'(o_code), 32'(pack_code()));
  endtask

  // Enter guess mg[], time the busy window, then check the scored result.
  task automatic play_guess(input string tag, input bit toggle);
    int n = 0;
    int r, w;
    for (int i = 0; i < P - 1; i++) pulse(mg[i], 1'b1);
    pulse(mg[P-1], 1'b0);
    while (o_busy === 1'b1 && n < 40) begin
      n++;
      if (toggle) begin
        load = (n >= 2 && n <= 5) ? n[0] : 1'b0;
        data = 4'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    load = 1'b0;
    score(r, w);
    if (e_gc < 8) e_gc++;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(2 * P));
    chk({tag, "_valid"}, 32'(o_valid), 1);
    chk({tag, "_red"},   32'(o_red), 32'(r));
    chk({tag, "_white"}, 32'(o_white), 32'(w));
    chk({tag, "_gc"},    32'(o_gc), 32'(e_gc));
    chk({tag, "_win"},   32'(o_win), 32'(r == P));
    chk({tag, "_lose"},  32'(o_lose), 32'(r != P && e_gc == 8));
    chk({tag, "_guess"}, 32'(o_guess), 32'(pack_guess()));
    e_over = (r == P) || (e_gc == 8);
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 32'(o_valid), 0);
  endtask

  task automatic set4(input int a, b, c, d, input bit is_code);
    if (is_code) begin mc[0] = a; mc[1] = b; mc[2] = c; mc[3] = d; end
    else         begin mg[0] = a; mg[1] = b; mg[2] = c; mg[3] = d; end
  endtask

  task automatic random_game(input string tag, input int maxc);
    do_new_game();
    for (int i = 0; i < P; i++) mc[i] = $urandom_range(0, maxc);
    load_code(0);
    for (int k = 0; k < 8 && !e_over; k++) begin
      for (int i = 0; i < P; i++) mg[i] = $urandom_range(0, maxc);
      if ($urandom_range(0, 5) == 0) for (int i = 0; i < P; i++) mg[i] = mc[i];
      play_guess(tag, 1'b0);
    end
  endtask

  initial begin
    int seen;
    logic [23:0] held;
    @(negedge clk);
    reset = 1'b0;
    select(1'b0);
    chk_zero("reset4");
    select(1'b1);
    chk_zero("reset6");
    select(1'b0);

    // Exact win, then DONE ignores loads
    set4(1, 2, 3, 4, 1); load_code(0);
    set4(1, 2, 3, 4, 0); play_guess("win", 1'b0);
    held = o_guess;
    pulse(7, 1'b1);
    chk("done_guess_hold", 32'(o_guess), 32'(held));
    chk("done_no_busy", 32'(o_busy), 0);

    do_new_game();
    chk_zero("newgame_after_win");
    set4(1, 1, 2, 2, 1); load_code(0);
    set4(2, 2, 1, 1, 0); play_guess("all_white", 1'b0);
    set4(1, 2, 2, 1, 0); play_guess("next_guess", 1'b0);

    do_new_game();
    set4(1, 1, 2, 3, 1); load_code(0);
    set4(3, 1, 1, 1, 0); play_guess("dup1", 1'b0);

    do_new_game();
    set4(1, 2, 3, 4, 1); load_code(0);
    set4(1, 1, 1, 1, 0); play_guess("dup2", 1'b0);

    // Eight misses lose the game
    do_new_game();
    set4(1, 2, 3, 4, 1); load_code(0);
    set4(0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) play_guess("lose", 1'b0);
    pulse(5, 1'b1);
    chk("lose_guess_hold", 32'(o_guess), 0);
    do_new_game();
    chk_zero("newgame_after_lose");

    // Held key writes one peg; load pulses while busy are ignored
    data = 4'd5;
    load = 1'b1;
    repeat (6) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("held_one_peg", 32'(o_code), 32'h5);
    set4(5, 6, 7, 0, 1); load_code(1);
    set4(5, 0, 6, 2, 0); play_guess("busy_pulses", 1'b1);

    // Reset on the third busy cycle aborts scoring
    do_new_game();
    set4(3, 3, 4, 4, 1); load_code(0);
    set4(3, 4, 3, 4, 0);
    for (int i = 0; i < 3; i++) pulse(mg[i], 1'b1);
    pulse(mg[3], 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_busy_3rd", 32'(o_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("abort");
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen++;
    end
    chk("abort_no_valid", 32'(seen), 0);
    e_gc = 0; e_over = 1'b0;

    random_game("rnd4a", 3);
    random_game("rnd4b", 2);
    random_game("rnd4c", 7);

    // Six-peg, 4-bit-colour instance
    select(1'b1);
    do_new_game();
    chk_zero("newgame6");
    mc[0] = 9; mc[1] = 9; mc[2] = 9; mc[3] = 1; mc[4] = 2; mc[5] = 3;
    load_code(0);
    mg[0] = 9; mg[1] = 1; mg[2] = 9; mg[3] = 9; mg[4] = 9; mg[5] = 9;
    play_guess("p6", 1'b0);
    random_game("rnd6a", 5);
    random_game("rnd6b", 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, expected summary before timeout");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
